// File: rtl/muxn_arb.sv
// N-channel registered funnel with round-robin arbitration, a manual steering mode and valid/ready on every channel.
// Define MUXN_ARB_FIXED_PRI_EN to replace round-robin with fixed lowest-index priority.
module muxn_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic                 manual,
    input  logic [SELW-1:0]      sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    logic             can_load;
    logic             grant_valid;
    logic             load;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  ptr;
    logic [WIDTH-1:0] grant_data;

    assign can_load = !out_valid || out_ready;

    always_comb begin : arbitrate
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (manual) begin
            if (int'(sel) < N) begin
                grant       = sel;
                grant_valid = in_valid[sel];
            end
        end else begin
            // Walk offsets high to low so the candidate closest to ptr is written last and wins.
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (in_valid[idx]) begin
                    grant       = SELW'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // in_ready is held low while reset is asserted, independent of the register state.
    assign load = rst_n && can_load && grant_valid;

    always_comb begin
        in_ready = '0;
        if (load) in_ready[grant] = 1'b1;
    end

`ifdef MUXN_ARB_FIXED_PRI_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load && !manual) begin
            ptr <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
        end
    end
`endif

    // Output register stage: reloads on any input transfer, empties on an output transfer alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muxn_arb.sv
// Randomized and directed bench for muxn_arb against a transaction-level reference model.
// Honours MUXN_ARB_FIXED_PRI_EN the same way the design does.
module tb_muxn_arb;

    localparam int N     = 4;
    localparam int WIDTH = 16;
    localparam int SELW  = 2;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               manual;
    logic [SELW-1:0]    sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [SELW-1:0]  m_chan;
    int               m_ptr;
    logic [N-1:0]     last_xfer;

    muxn_arb #(.N(N), .WIDTH(WIDTH), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .manual    (manual),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_chan    = '0;
        m_ptr     = 0;
        last_xfer = '0;
    endtask

    // Which channel may transfer this cycle, as a one-hot vector.
    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int c;
        int start;
        r = '0;
        if (m_valid && !out_ready) return r;
        if (manual) begin
            if (int'(sel) < N && in_valid[sel]) r[sel] = 1'b1;
            return r;
        end
`ifdef MUXN_ARB_FIXED_PRI_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            c = (start + k) % N;
            if (in_valid[c]) begin
                r[c] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Called at a falling edge after inputs are set; returns at the next falling edge.
    task automatic step();
        logic [N-1:0] er;
        #1;
        er = model_ready();
        check("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        last_xfer = er;
        if (|er) begin
            for (int c = 0; c < N; c++) begin
                if (er[c]) begin
                    m_data = in_data[c*WIDTH +: WIDTH];
                    m_chan = SELW'(c);
                    if (!manual) m_ptr = (c + 1) % N;
                end
            end
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_chan", 32'(out_chan), 32'(m_chan));
    endtask

    // Asynchronous reset asserted mid-cycle; called at a falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_chan", 32'(out_chan), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] rr_data [5];
    logic [SELW-1:0]  rr_chan [5];

    initial begin
        rst_n     = 1'b0;
        in_valid  = '1;
        in_data   = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        out_ready = 1'b1;
        manual    = 1'b0;
        sel       = '0;
        model_reset();
`ifdef MUXN_ARB_FIXED_PRI_EN
        rr_data = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
        rr_chan = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        rr_data = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hAAAA};
        rr_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("hold_rst_in_ready", 32'(in_ready), 32'(0));
        check("hold_rst_out_valid", 32'(out_valid), 32'(0));
        check("hold_rst_out_data", 32'(out_data), 32'(0));
        rst_n = 1'b1;
        #1;
        check("first_in_ready", 32'(in_ready), 32'(4'b0001));

        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_data", 32'(out_data), 32'(rr_data[i]));
            check("rr_chan", 32'(out_chan), 32'(rr_chan[i]));
        end

        // Drop a live word with a mid-cycle reset.
        do_reset();

        out_ready = 1'b1;
        step();
        check("bp_first", 32'(out_data), 32'(16'hAAAA));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_data", 32'(out_data), 32'(16'hAAAA));
            check("bp_hold_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        step();
`ifdef MUXN_ARB_FIXED_PRI_EN
        check("bp_next", 32'(out_data), 32'(16'hAAAA));
`else
        check("bp_next", 32'(out_data), 32'(16'hBBBB));
`endif

        manual   = 1'b1;
        sel      = 2'd2;
        in_valid = 4'b0101;
        in_data[2*WIDTH +: WIDTH] = 16'hAB12;
        step();
        check("man_data", 32'(out_data), 32'(16'hAB12));
        check("man_chan", 32'(out_chan), 32'(2));
        sel = 2'd1;
        step();
        check("man_drain", 32'(out_valid), 32'(0));

        manual   = 1'b0;
        in_valid = '1;
        step();
`ifdef MUXN_ARB_FIXED_PRI_EN
        check("ptr_keep", 32'(out_chan), 32'(0));
`else
        check("ptr_keep", 32'(out_chan), 32'(2));
`endif
        in_valid = 4'b0010;
        step();
        check("wrap_skip", 32'(out_chan), 32'(1));
        in_valid = '1;
        step();
`ifdef MUXN_ARB_FIXED_PRI_EN
        check("wrap_ptr", 32'(out_chan), 32'(0));
`else
        check("wrap_ptr", 32'(out_chan), 32'(2));
`endif

        for (int t = 0; t < 3000; t++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) manual = ~manual;
            if ($urandom_range(0, 3) == 0) sel = SELW'($urandom_range(0, N - 1));
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || last_xfer[i]) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    in_data[i*WIDTH +: WIDTH] = 16'($urandom);
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
